// File: rtl/char_render_pkg.sv
// char_render_pkg: display geometry, sprite colours, start position and blink FSM states.
package char_render_pkg;
  localparam int WIDTH = 96;
  localparam int HEIGHT = 64;
  localparam int BLINK_FRAMES = 15;
  localparam logic [15:0] COL_BODY = 16'hFFE0;
  localparam logic [15:0] COL_EDGE = 16'hF800;
  localparam logic [15:0] COL_CD = 16'h07FF;
  localparam logic [6:0] START_X = 7'd2;
  localparam logic [5:0] START_Y = 6'd13;
  typedef enum logic {PLAY = 1'b0, WIN = 1'b1} blink_state_t;
endpackage

// File: rtl/char_sprite_rom.sv
// char_sprite_rom: 3x3 sprite lookup, corners in edge colour, remaining cells in body colour.
module char_sprite_rom
  import char_render_pkg::*;
#(
  parameter logic [15:0] BODY = COL_BODY,
  parameter logic [15:0] EDGE = COL_EDGE,
  parameter logic [15:0] CD = COL_CD
) (
  input  logic [1:0]  dx,
  input  logic [1:0]  dy,
  input  logic        cd,
  output logic [15:0] colour,
  output logic        opaque
);
  always_comb begin
    opaque = (dx != 2'd3) && (dy != 2'd3);
    colour = (!dx[0] && !dy[0]) ? EDGE : cd ? CD : BODY;
  end
endmodule

// File: rtl/char_render.sv
// char_render: overlays the per-frame shadowed character sprite onto the background pixel stream.
// Two-stage pipeline; shadow state is snapshotted into S1 so a pixel issued with frame_begin sees the old frame.
module char_render
  import char_render_pkg::*;
#(
  parameter int WIDTH = char_render_pkg::WIDTH,
  parameter int HEIGHT = char_render_pkg::HEIGHT,
  parameter int BLINK_FRAMES = char_render_pkg::BLINK_FRAMES,
  parameter logic [15:0] COL_BODY = char_render_pkg::COL_BODY,
  parameter logic [15:0] COL_EDGE = char_render_pkg::COL_EDGE,
  parameter logic [15:0] COL_CD = char_render_pkg::COL_CD
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        frame_begin,
  input  logic [12:0] pix_idx,
  input  logic        pix_req,
  input  logic [15:0] bg_data,
  input  logic [6:0]  x,
  input  logic [5:0]  y,
  input  logic        win,
  input  logic [2:0]  cd_cnt,
  output logic [15:0] pix_data,
  output logic        pix_valid
);
  blink_state_t state, state_nx;
  logic [7:0]  blink_cnt, blink_cnt_nx;
  logic        blink_on, blink_on_nx, last;
  logic [6:0]  sx, s1_sx, s1_col, s1_row;
  logic [5:0]  sy, s1_sy;
  logic        swin;
  logic [2:0]  scd;
  logic [15:0] s1_bg, spr_col, px_nx;
  logic        s1_oob, s1_req, s1_cd, s1_vis, hit, opaque;
  logic [7:0]  c8, r8, x8, y8;
  logic [1:0]  dx, dy;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      state     <= PLAY;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      sx        <= START_X;
      sy        <= START_Y;
      swin      <= 1'b0;
      scd       <= '0;
    end else if (frame_begin) begin
      state     <= state_nx;
      blink_cnt <= blink_cnt_nx;
      blink_on  <= blink_on_nx;
      sx        <= x;
      sy        <= y;
      swin      <= win;
      scd       <= cd_cnt;
    end
  assign last = blink_cnt == 8'(BLINK_FRAMES - 1);
  always_comb begin
    state_nx     = win ? WIN : PLAY;
    blink_cnt_nx = '0;
    blink_on_nx  = 1'b1;
    if (state == WIN && win) begin
      blink_cnt_nx = last ? '0 : blink_cnt + 8'd1;
      blink_on_nx  = last ? !blink_on : blink_on;
    end
  end
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      s1_col    <= '0;
      s1_row    <= '0;
      s1_bg     <= '0;
      s1_oob    <= 1'b0;
      s1_req    <= 1'b0;
      s1_sx     <= START_X;
      s1_sy     <= START_Y;
      s1_cd     <= 1'b0;
      s1_vis    <= 1'b1;
      pix_data  <= '0;
      pix_valid <= 1'b0;
    end else begin
      s1_col    <= 7'(pix_idx % 13'(WIDTH));
      s1_row    <= 7'(pix_idx / 13'(WIDTH));
      s1_bg     <= bg_data;
      s1_oob    <= pix_idx >= 13'(WIDTH * HEIGHT);
      s1_req    <= pix_req;
      s1_sx     <= sx;
      s1_sy     <= sy;
      s1_cd     <= scd != 3'd0;
      s1_vis    <= !swin || blink_on;
      pix_valid <= s1_req;
      if (s1_req) pix_data <= px_nx;
    end
  // 8-bit compares so a sprite touching column/row 0 clips instead of wrapping
  always_comb begin
    c8  = {1'b0, s1_col};
    r8  = {1'b0, s1_row};
    x8  = {1'b0, s1_sx};
    y8  = {2'b0, s1_sy};
    hit = (c8 + 8'd1 >= x8) && (c8 <= x8 + 8'd1) && (r8 + 8'd1 >= y8) && (r8 <= y8 + 8'd1);
    dx  = 2'(c8 - x8 + 8'd1);
    dy  = 2'(r8 - y8 + 8'd1);
  end
  char_sprite_rom #(.BODY(COL_BODY), .EDGE(COL_EDGE), .CD(COL_CD)) u_rom (
    .dx(dx), .dy(dy), .cd(s1_cd), .colour(spr_col), .opaque(opaque)
  );
  assign px_nx = s1_oob ? 16'h0000 : (hit && opaque && s1_vis) ? spr_col : s1_bg;
endmodule

// File: tb/tb_char_render.sv
// tb_char_render: directed checks of sprite overlay, frame latching, clipping, countdown, blink and pipeline timing.
module tb_char_render;
  logic        clk = 1'b0;
  logic        clr_n = 1'b1;
  logic        frame_begin = 1'b0;
  logic [12:0] pix_idx = '0;
  logic        pix_req = 1'b0;
  logic [15:0] bg_data = '0;
  logic [6:0]  x = 7'd2;
  logic [5:0]  y = 6'd13;
  logic        win = 1'b0;
  logic [2:0]  cd_cnt = '0;
  logic [15:0] pix_data;
  logic        pix_valid;
  int checks = 0;
  int failures = 0;
  logic [15:0] got [0:6143];
  logic [15:0] d;
  logic        v;
  int diff, nval;
  localparam logic [15:0] BODY = 16'hFFE0, EDGE = 16'hF800, CDC = 16'h07FF;
  localparam int VIS [1:7] = '{1, 1, 0, 0, 1, 1, 0};

  char_render #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .clr_n(clr_n), .frame_begin(frame_begin), .pix_idx(pix_idx), .pix_req(pix_req),
    .bg_data(bg_data), .x(x), .y(y), .win(win), .cd_cnt(cd_cnt), .pix_data(pix_data), .pix_valid(pix_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bgf(int i);
    return 16'(i * 3 + 'h1234);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fb(logic [6:0] nx, logic [5:0] ny, logic nw, logic [2:0] nc);
    x = nx; y = ny; win = nw; cd_cnt = nc; frame_begin = 1'b1;
    step();
    frame_begin = 1'b0;
  endtask

  task automatic px(int idx, output logic [15:0] data, output logic valid);
    pix_idx = 13'(idx); bg_data = bgf(idx); pix_req = 1'b1;
    step();
    pix_req = 1'b0;
    chk("lat1", {31'b0, pix_valid}, 32'd0);
    step();
    data = pix_data; valid = pix_valid;
  endtask

  task automatic sweep(output int ndiff, output int nv);
    ndiff = 0; nv = 0;
    for (int i = 0; i <= 6144; i++) begin
      pix_req = (i < 6144); pix_idx = 13'(i); bg_data = bgf(i);
      step();
      if (i == 0) chk("sweep_lat0", {31'b0, pix_valid}, 32'd0);
      if (i == 1) chk("sweep_lat1", {31'b0, pix_valid}, 32'd1);
      if (i >= 1) begin
        got[i-1] = pix_data;
        nv += int'(pix_valid);
        if (pix_data !== bgf(i - 1)) ndiff++;
      end
    end
    pix_req = 1'b0;
    step();
  endtask

  initial begin
    #2 clr_n = 1'b0;
    step(); step();
    chk("rst_data", {16'b0, pix_data}, 32'h0);
    chk("rst_valid", {31'b0, pix_valid}, 32'd0);
    @(negedge clk); clr_n = 1'b1;
    px(1249, d, v);
    chk("reset_pos", {16'b0, d}, {16'b0, BODY});
    chk("reset_pos_v", {31'b0, v}, 32'd1);
    fb(7'd2, 6'd13, 1'b0, 3'd0);
    sweep(diff, nval);
    chk("diff9", 32'(diff), 32'd9);
    chk("nvalid", 32'(nval), 32'd6144);
    chk("idx1151", {16'b0, got[1151]}, {16'b0, bgf(1151)});
    chk("idx1249", {16'b0, got[1249]}, {16'b0, BODY});
    chk("idx1152", {16'b0, got[1152]}, {16'b0, bgf(1152)});
    chk("idx1153", {16'b0, got[1153]}, {16'b0, EDGE});
    chk("idx1250", {16'b0, got[1250]}, {16'b0, BODY});
    chk("idx1347", {16'b0, got[1347]}, {16'b0, EDGE});
    x = 7'd40;
    px(1249, d, v);
    chk("nolatch_old", {16'b0, d}, {16'b0, BODY});
    px(1288, d, v);
    chk("nolatch_new", {16'b0, d}, {16'b0, bgf(1288)});
    frame_begin = 1'b1; pix_idx = 13'd1249; bg_data = bgf(1249); pix_req = 1'b1;
    step();
    frame_begin = 1'b0; pix_req = 1'b0;
    step();
    chk("samecyc_old", {16'b0, pix_data}, {16'b0, BODY});
    px(1249, d, v);
    chk("moved_old", {16'b0, d}, {16'b0, bgf(1249)});
    px(1288, d, v);
    chk("moved_ctr", {16'b0, d}, {16'b0, BODY});
    px(1191, d, v);
    chk("moved_edge", {16'b0, d}, {16'b0, EDGE});
    fb(7'd0, 6'd0, 1'b0, 3'd0);
    sweep(diff, nval);
    chk("clip_diff4", 32'(diff), 32'd4);
    chk("clip0", {16'b0, got[0]}, {16'b0, BODY});
    chk("clip1", {16'b0, got[1]}, {16'b0, BODY});
    chk("clip96", {16'b0, got[96]}, {16'b0, BODY});
    chk("clip97", {16'b0, got[97]}, {16'b0, EDGE});
    chk("clip95", {16'b0, got[95]}, {16'b0, bgf(95)});
    chk("clip6143", {16'b0, got[6143]}, {16'b0, bgf(6143)});
    fb(7'd2, 6'd13, 1'b0, 3'd3);
    px(1249, d, v);
    chk("cd_body", {16'b0, d}, {16'b0, CDC});
    px(1153, d, v);
    chk("cd_edge", {16'b0, d}, {16'b0, EDGE});
    px(1250, d, v);
    chk("cd_ctr", {16'b0, d}, {16'b0, CDC});
    fb(7'd95, 6'd63, 1'b0, 3'd0);
    px(6143, d, v);
    chk("br_ctr", {16'b0, d}, {16'b0, BODY});
    px(6142, d, v);
    chk("br_left", {16'b0, d}, {16'b0, BODY});
    px(6046, d, v);
    chk("br_edge", {16'b0, d}, {16'b0, EDGE});
    px(6048, d, v);
    chk("br_nowrap", {16'b0, d}, {16'b0, bgf(6048)});
    for (int f = 1; f <= 7; f++) begin
      fb(7'd2, 6'd13, 1'b1, 3'd0);
      px(1250, d, v);
      chk($sformatf("blink_f%0d", f), {16'b0, d}, {16'b0, (VIS[f] != 0) ? BODY : bgf(1250)});
    end
    fb(7'd2, 6'd13, 1'b0, 3'd0);
    px(1250, d, v);
    chk("win_drop", {16'b0, d}, {16'b0, BODY});
    px(6144, d, v);
    chk("oob_data", {16'b0, d}, 32'h0);
    chk("oob_valid", {31'b0, v}, 32'd1);
    pix_idx = 13'd10; bg_data = bgf(10); pix_req = 1'b1;
    step();
    pix_req = 1'b0;
    step();
    chk("gap_v0", {31'b0, pix_valid}, 32'd1);
    pix_idx = 13'd11; bg_data = bgf(11); pix_req = 1'b1;
    step();
    pix_req = 1'b0;
    chk("gap_bubble", {31'b0, pix_valid}, 32'd0);
    chk("gap_hold", {16'b0, pix_data}, {16'b0, bgf(10)});
    step();
    chk("gap_v2", {31'b0, pix_valid}, 32'd1);
    chk("gap_d2", {16'b0, pix_data}, {16'b0, bgf(11)});
    fb(7'd40, 6'd20, 1'b0, 3'd0);
    pix_idx = 13'd1250; bg_data = bgf(1250); pix_req = 1'b1;
    step(); step();
    chk("pre_rst_v", {31'b0, pix_valid}, 32'd1);
    #2 clr_n = 1'b0;
    #1;
    chk("async_v", {31'b0, pix_valid}, 32'd0);
    chk("async_d", {16'b0, pix_data}, 32'h0);
    pix_req = 1'b0;
    @(negedge clk); clr_n = 1'b1;
    px(1250, d, v);
    chk("post_rst_d", {16'b0, d}, {16'b0, BODY});
    chk("post_rst_v", {31'b0, v}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/char_render.md
Name: char_render

Overview:
- Reader/display end of the character position interface: consumes the walker's x/y/win/countdown state and draws the character sprite into the 96x64 OLED pixel stream.
- Sits between the maze background generator and the OLED driver.
- Per-pixel it either overlays a 3x3 sprite or passes the background colour through.
- Latches position once per frame so the sprite never tears; blinks the sprite after a win.

Parameters:
- WIDTH, 96, display columns.
- HEIGHT, 64, display rows.
- BLINK_FRAMES, 15, frames per blink half-period in win state (1..255).
- COL_BODY, 16'hFFE0, RGB565 sprite body colour in normal play.
- COL_EDGE, 16'hF800, RGB565 sprite corner colour.
- COL_CD, 16'h07FF, RGB565 sprite colour while countdown is active.

Ports:
- clk, input, 1, system clock.
- clr_n, input, 1, asynchronous active-low reset.
- frame_begin, input, 1, single-cycle pulse from the OLED driver at the start of each frame (vblank).
- pix_idx, input, 13, pixel index requested, row-major, 0..WIDTH*HEIGHT-1.
- pix_req, input, 1, pix_idx valid this cycle.
- bg_data, input, 16, background RGB565 for the same pix_idx, same cycle.
- x, input, 7, character column (centre of sprite).
- y, input, 6, character row (centre of sprite).
- win, input, 1, level complete.
- cd_cnt, input, 3, countdown value; nonzero = countdown active.
- pix_data, output, 16, RGB565 pixel out.
- pix_valid, output, 1, pix_data valid.

Behaviour:
- Reset (clr_n low, async):
  - pix_data=0, pix_valid=0.
  - Shadow regs: sx=2, sy=13, swin=0, scd=0.
  - blink_cnt=0, blink_on=1.
- Shadow latch: on the clk edge where frame_begin=1, capture x,y,win,cd_cnt into sx,sy,swin,scd.
  - A pixel requested in the same cycle as frame_begin uses the old shadow values.
  - Inputs are never used unshadowed.
- Pipeline, latency 2 cycles, fully pipelined (one pixel per cycle, no stalls):
  - S1 registers:
    - col = pix_idx % WIDTH, row = pix_idx / WIDTH.
    - bg_data.
    - oob = (pix_idx >= WIDTH*HEIGHT).
    - The req bit.
  - S2 registers:
    - pix_data.
    - pix_valid = S1 req.
  - pix_req=0 produces a bubble: pix_valid=0 two cycles later. pix_data holds its last value.
- Hit test in S2:
  - dx = col - sx + 1, dy = row - sy + 1, computed at 8 bits, no wrap.
  - Hit when (col+1 >= sx) && (col <= sx+1) && (row+1 >= sy) && (row <= sy+1).
  - sx=0 or sy=0 therefore clips the sprite rather than wrapping. A sprite at col 95/row 63 clips at the right and bottom edges.
- Sprite map (dx,dy in 0..2):
  - Corners (dx,dy both in {0,2}) = COL_EDGE.
  - All other cells = body colour.
- Body colour is COL_CD if scd != 0, else COL_BODY.
- Output mux priority:
  1. oob → 16'h0000.
  2. Hit and sprite visible → sprite colour.
  3. Otherwise → bg_data.
- Visibility: sprite visible iff (!swin) || blink_on.
- Blink FSM, updated on frame_begin only:
  - States PLAY and WIN.
  - PLAY: blink_cnt=0, blink_on=1. On frame_begin with win=1, go to WIN.
  - WIN:
    - On each frame_begin, blink_cnt++.
    - When blink_cnt == BLINK_FRAMES-1: blink_cnt=0 and toggle blink_on.
    - On frame_begin with win=0, go to PLAY (blink_on=1, blink_cnt=0).
  - Transition uses the same-edge sampled win, so the FSM and swin agree on the frame.
- Reset mid-frame: outputs drop immediately. The first valid pixel after release appears 2 cycles after the first pix_req.

Decomposition:
- Shared package/header: WIDTH, HEIGHT, RGB565 colour constants, start position (2,13), FSM state encodings (PLAY=0, WIN=1).
- One natural sub-module, char_sprite_rom: combinational (dx,dy,cd)→colour/opaque.
- Blink FSM and pipeline stay in char_render.

Test Plan:
- Reset then frame_begin with x=2,y=13, sweep all 6144 pix_idx:
  - Exactly 9 pixels differ from bg_data.
  - Idx 1151 (col 95, row 11) = bg_data.
  - Idx 1249 (col 1, row 13) = COL_BODY.
  - Idx 1152 (col 0, row 12) = bg.
  - Idx 1153 (col 1, row 12) = COL_EDGE.
  - Latency 2 cycles.
- Change x to 40 mid-frame without frame_begin → sprite stays at col 2 until the next frame_begin. Same-cycle pixel request uses old position.
- Edge clip: x=0,y=0 → 4 pixels hit: idx 0 = body (centre), idx 1 = body, idx 96 = body, idx 97 = COL_EDGE. No pixels at row 63 or col 95 are hit.
- cd_cnt=3 at frame_begin → body pixels = COL_CD. Corners stay COL_EDGE.
- win=1, BLINK_FRAMES=2:
  - Sprite visible frames 1-2, hidden frames 3-4, visible frames 5-6.
  - Win drop on frame_begin → visible next frame.
- pix_idx=6144 with pix_req → pix_data=0, pix_valid=1. Req gap → pix_valid=0 exactly 2 cycles later. clr_n low mid-stream → pix_valid=0 asynchronously.
